// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC step function, frame state type and constants
// Used by both the CRC generator and the stream checker.
package crc_pkg;

  localparam int CRC_MAXW = 64;
  localparam logic [CRC_MAXW-1:0] CRC_RESIDUE = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_t;

  function automatic int crc_words(input int crcw, input int dataw);
    return crcw / dataw;
  endfunction

  // Non-reflected shift-XOR over dataw bits, MSB first; only the low crcw bits are live.
  function automatic logic [CRC_MAXW-1:0] crc_step(
    input logic [CRC_MAXW-1:0] crc,
    input logic [CRC_MAXW-1:0] data,
    input logic [CRC_MAXW-1:0] poly,
    input int                  crcw,
    input int                  dataw
  );
    logic [CRC_MAXW-1:0] mask;
    logic [CRC_MAXW-1:0] top;
    logic [CRC_MAXW-1:0] r;
    logic                fb;
    mask = (CRC_MAXW'(1) << crcw) - CRC_MAXW'(1);
    top  = CRC_MAXW'(1) << (crcw - 1);
    r    = crc & mask;
    for (int i = CRC_MAXW - 1; i >= 0; i--) begin
      if (i < dataw) begin
        fb = (|(r & top)) ^ (|(data & (CRC_MAXW'(1) << i)));
        r  = (r << 1) & mask;
        if (fb) r = r ^ (poly & mask);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_trailer_buffer.sv
// rtl/crc_trailer_buffer.sv - DEPTH-word shift FIFO holding the not-yet-known-to-be-payload words
// Slot 0 is the oldest word; flush empties the buffer and may load one word in the same cycle.
module crc_trailer_buffer #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 2,
  parameter int CNTW      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic                 i_flush,
  input  logic [DATAWIDTH-1:0] i_dat,
  output logic [DATAWIDTH-1:0] o_head,
  output logic [CNTW-1:0]      o_cnt
);

  logic [CNTW-1:0] r_cnt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [DATAWIDTH-1:0] r_word;
    logic [DATAWIDTH-1:0] w_above;

    if (g < DEPTH - 1) begin : g_mid
      assign w_above = g_slot[g+1].r_word;
    end else begin : g_top
      assign w_above = '0;
    end

    // On pop+push the new word lands in the slot just vacated at the tail.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_word <= '0;
      end else if (i_flush) begin
        if (g == 0 && i_push) r_word <= i_dat;
      end else if (i_pop) begin
        if (i_push && r_cnt == CNTW'(g + 1)) r_word <= i_dat;
        else                                 r_word <= w_above;
      end else if (i_push && r_cnt == CNTW'(g)) begin
        r_word <= i_dat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= i_push ? CNTW'(1) : '0;
    end else if (i_pop && !i_push) begin
      r_cnt <= r_cnt - CNTW'(1);
    end else if (i_push && !i_pop) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign o_head = g_slot[0].r_word;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/crc_stream_checker.sv
// rtl/crc_stream_checker.sv - strips an MSB-first CRC trailer from framed words and flags pass/fail
// Payload leaves N words behind the input; the last payload word carries the result.
module crc_stream_checker
  import crc_pkg::*;
#(
  parameter int                  DATAWIDTH  = 8,
  parameter int                  CRCWIDTH   = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005,
  parameter logic [CRCWIDTH-1:0] INITCRC    = 16'hFFFF,
  parameter int                  CNTWIDTH   = 16
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic [DATAWIDTH-1:0] i_dat,
  input  logic                 i_val,
  input  logic                 i_sop,
  input  logic                 i_eop,
  output logic                 i_rdy,
  output logic [DATAWIDTH-1:0] o_dat,
  output logic                 o_val,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic                 o_err,
  input  logic                 o_rdy,
  output logic                 runt,
  output logic                 abort,
  output logic [CNTWIDTH-1:0]  good_cnt,
  output logic [CNTWIDTH-1:0]  bad_cnt
);

  localparam int N  = crc_words(CRCWIDTH, DATAWIDTH);
  localparam int CW = $clog2(N + 1);

  frame_state_t         r_state;
  logic [CRCWIDTH-1:0]  r_crc;
  logic                 r_first;

  logic                 w_in_frame;
  logic                 w_full;
  logic                 w_acc;
  logic                 w_cont;
  logic                 w_emit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_pass;
  logic [CRCWIDTH-1:0]  w_seed;
  logic [CRCWIDTH-1:0]  w_crc_nxt;
  logic [DATAWIDTH-1:0] w_head;
  logic [CW-1:0]        w_cnt;

  assign w_in_frame = (r_state == ST_FRAME);
  assign w_full     = (w_cnt == CW'(N));
  assign i_rdy      = !w_in_frame | !w_full | !o_val | o_rdy;
  assign w_acc      = i_val & i_rdy;
  assign w_cont     = w_acc & !i_sop & w_in_frame;
  assign w_emit     = w_cont & w_full;

  // The eop word is never stored: the buffer is flushed and its head is the last payload word.
  assign w_push  = (w_acc & i_sop & !i_eop) | (w_cont & !i_eop);
  assign w_pop   = w_emit & !i_eop;
  assign w_flush = w_acc & (i_sop | (w_in_frame & i_eop));

  assign w_seed    = i_sop ? INITCRC : r_crc;
  assign w_crc_nxt = CRCWIDTH'(crc_step(CRC_MAXW'(w_seed), CRC_MAXW'(i_dat),
                                        CRC_MAXW'(POLYNOMIAL), CRCWIDTH, DATAWIDTH));
  assign w_pass    = (w_crc_nxt == CRCWIDTH'(CRC_RESIDUE));

  crc_trailer_buffer #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (N),
    .CNTW      (CW)
  ) u_trailer (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_dat   (i_dat),
    .o_head  (w_head),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_crc    <= INITCRC;
      r_first  <= 1'b0;
      o_dat    <= '0;
      o_val    <= 1'b0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_err    <= 1'b0;
      runt     <= 1'b0;
      abort    <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      runt  <= 1'b0;
      abort <= 1'b0;
      if (o_val && o_rdy) o_val <= 1'b0;

      if (w_acc && i_sop) begin
        r_crc   <= w_crc_nxt;
        r_first <= 1'b1;
        abort   <= w_in_frame;
        if (i_eop) begin
          runt    <= 1'b1;
          r_state <= ST_IDLE;
        end else begin
          r_state <= ST_FRAME;
        end
      end else if (w_cont) begin
        r_crc <= w_crc_nxt;
        if (w_emit) begin
          o_val   <= 1'b1;
          o_dat   <= w_head;
          o_sop   <= r_first;
          o_eop   <= i_eop;
          o_err   <= i_eop & !w_pass;
          r_first <= 1'b0;
          if (i_eop) begin
            if (w_pass) good_cnt <= good_cnt + CNTWIDTH'(1);
            else        bad_cnt  <= bad_cnt + CNTWIDTH'(1);
          end
        end
        if (i_eop) begin
          r_state <= ST_IDLE;
          if (!w_full) runt <= 1'b1;
        end
      end
    end
  end

endmodule
